// File: rtl/mixcol_seq.sv
// Sequential AES MixColumns / InvMixColumns engine.
// One GF(2^8) product per cycle; 64 RUN cycles per 128-bit state.
//
// state | meaning
// IDLE  | waiting for start; dout holds the last result
// RUN   | one product accumulated per cycle, 64 cycles
// DONE  | result valid, done pulse for one cycle
module mixcol_seq (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         inv,
  input  logic [127:0] din,
  output logic         busy,
  output logic         done,
  output logic [127:0] dout
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t       state, state_nxt;
  logic [127:0] st_q;
  logic         mode_q;
  logic [5:0]   cnt_q;
  logic [7:0]   acc_q;

  logic [1:0] col, row, term, coef_sel;
  logic [3:0] src_idx, dst_idx;
  logic [7:0] src, coef, prod, acc_sum;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  assign {col, row, term} = cnt_q;
  assign src_idx  = {col, term};
  assign dst_idx  = {col, row};
  // Row r of the matrix is row 0 rotated right by r, so the coefficient is row0[term-row].
  assign coef_sel = term - row;

  always_comb begin
    coef = 8'h01;
    case ({mode_q, coef_sel})
      3'b0_00: coef = 8'h02;
      3'b0_01: coef = 8'h03;
      3'b0_10: coef = 8'h01;
      3'b0_11: coef = 8'h01;
      3'b1_00: coef = 8'h0E;
      3'b1_01: coef = 8'h0B;
      3'b1_10: coef = 8'h0D;
      3'b1_11: coef = 8'h09;
      default: coef = 8'h01;
    endcase
  end

  // Byte k lives at bits [127-8k -: 8]; ~idx is 15-idx for a 4-bit index.
  assign src     = st_q[{~src_idx, 3'b000} +: 8];
  assign prod    = gf_mul(coef, src);
  assign acc_sum = acc_q ^ prod;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (cnt_q == 6'd63) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= '0;
      mode_q <= 1'b0;
      cnt_q  <= '0;
      acc_q  <= '0;
      dout   <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          st_q   <= din;
          mode_q <= inv;
          cnt_q  <= '0;
          acc_q  <= '0;
        end
        RUN: begin
          cnt_q <= cnt_q + 6'd1;
          if (term == 2'd3) begin
            dout[{~dst_idx, 3'b000} +: 8] <= acc_sum;
            acc_q <= '0;
          end else begin
            acc_q <= acc_sum;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mixcol_seq.sv
// Directed bench for mixcol_seq: expected results queued at launch, checked on done.
module tb_mixcol_seq;

  logic         clk = 1'b0;
  logic         rst, start, inv;
  logic [127:0] din;
  logic         busy, done;
  logic [127:0] dout;

  int           checks = 0;
  int           failures = 0;
  logic [127:0] exp_q[$];

  localparam logic [127:0] FIPS_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] FIPS_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] ALL_80   = {16{8'h80}};

  always #5 clk = ~clk;

  mixcol_seq dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .inv   (inv),
    .din   (din),
    .busy  (busy),
    .done  (done),
    .dout  (dout)
  );

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mulc(input logic [7:0] a, input int c);
    logic [7:0] m2, m4, m8;
    m2 = xt(a);
    m4 = xt(m2);
    m8 = xt(m4);
    case (c)
      1:  return a;
      2:  return m2;
      3:  return m2 ^ a;
      9:  return m8 ^ a;
      11: return m8 ^ m2 ^ a;
      13: return m8 ^ m4 ^ a;
      14: return m8 ^ m4 ^ m2;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s, input bit inverse);
    int         row0[4];
    logic [127:0] m;
    logic [7:0] acc;
    if (inverse) begin
      row0[0] = 14; row0[1] = 11; row0[2] = 13; row0[3] = 9;
    end else begin
      row0[0] = 2;  row0[1] = 3;  row0[2] = 1;  row0[3] = 1;
    end
    m = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int t = 0; t < 4; t++)
          acc = acc ^ mulc(s[127-8*(4*c+t) -: 8], row0[(t - r + 4) % 4]);
        m[127-8*(4*c+r) -: 8] = acc;
      end
    return m;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [127:0] d, input logic i, input logic [127:0] e);
    din   = d;
    inv   = i;
    start = 1'b1;
    exp_q.push_back(e);
    tick();
    start = 1'b0;
    din   = ~d;
    inv   = ~i;
    chk("busy_after_start", {127'd0, busy}, 128'd1);
  endtask

  // Waits for done; optional stray start pulses at the given RUN steps (-1 = none).
  task automatic finish(input string tag, input int p1, input int p2);
    int          k;
    bit          got;
    int          extra;
    logic [127:0] e;
    k   = 0;
    got = 1'b0;
    while (!got && k < 80) begin
      if (k == p1 || k == p2) begin
        start = 1'b1;
        din   = 128'h0123_4567_89ab_cdef_0f1e_2d3c_4b5a_6978;
        inv   = 1'b1;
      end
      tick();
      start = 1'b0;
      k++;
      if (done) got = 1'b1;
    end
    chk({tag, "_done_seen"}, {127'd0, got}, 128'd1);
    chk({tag, "_latency"}, 128'(k), 128'd64);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    if (got) chk({tag, "_dout"}, dout, e);
    tick();
    chk({tag, "_done_one_cycle"}, {127'd0, done}, 128'd0);
    chk({tag, "_idle_after"}, {127'd0, busy}, 128'd0);
    extra = 0;
    for (int j = 0; j < 3; j++) begin
      tick();
      if (done || busy) extra++;
    end
    chk({tag, "_no_extra_op"}, 128'(extra), 128'd0);
    chk({tag, "_dout_held"}, dout, e);
  endtask

  initial begin
    logic [127:0] r;
    int d1, d2, ndone;

    rst = 1'b1; start = 1'b0; inv = 1'b0; din = '0;
    #12;
    chk("reset_busy", {127'd0, busy}, 128'd0);
    chk("reset_done", {127'd0, done}, 128'd0);
    chk("reset_dout", dout, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    launch(FIPS_IN, 1'b0, FIPS_OUT);
    finish("fwd_fips", -1, -1);

    launch(FIPS_OUT, 1'b1, FIPS_IN);
    finish("inv_fips", -1, -1);

    launch(FIPS_IN, 1'b0, FIPS_OUT);
    finish("busy_protect", 10, 40);

    launch(ALL_80, 1'b0, ALL_80);
    finish("reduction", -1, -1);

    // Abort mid-RUN: outputs clear asynchronously, no done follows.
    launch(FIPS_OUT, 1'b1, FIPS_IN);
    repeat (29) tick();
    rst = 1'b1;
    #1;
    chk("abort_busy", {127'd0, busy}, 128'd0);
    chk("abort_done", {127'd0, done}, 128'd0);
    chk("abort_dout", dout, 128'd0);
    void'(exp_q.pop_back());
    #2 rst = 1'b0;
    ndone = 0;
    for (int j = 0; j < 70; j++) begin
      tick();
      if (done || busy) ndone++;
    end
    chk("abort_no_done", 128'(ndone), 128'd0);
    launch(FIPS_IN, 1'b0, FIPS_OUT);
    finish("after_abort", -1, -1);

    // Start held high across two operations.
    din = FIPS_IN; inv = 1'b0; start = 1'b1;
    exp_q.push_back(FIPS_OUT);
    d1 = -1; d2 = -1; ndone = 0;
    for (int k = 1; k <= 140; k++) begin
      tick();
      if (done) begin
        ndone++;
        if (d1 < 0) begin
          d1 = k;
          chk("b2b_first_dout", dout, exp_q.pop_front());
          din = '0; inv = 1'b1;
          exp_q.push_back('0);
        end else if (d2 < 0) begin
          d2 = k;
          if (exp_q.size() > 0) chk("b2b_second_dout", dout, exp_q.pop_front());
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    chk("b2b_first_latency", 128'(d1), 128'd65);
    chk("b2b_spacing", 128'(d2 - d1), 128'd66);
    chk("b2b_pulse_count", 128'(ndone), 128'd2);
    chk("b2b_queue_drained", 128'(exp_q.size()), 128'd0);
    exp_q.delete();
    repeat (3) tick();

    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    launch(r, 1'b0, mix(r, 1'b0));
    finish("rand_fwd", -1, -1);
    launch(mix(r, 1'b0), 1'b1, r);
    finish("rand_inv", -1, -1);

    // Start held through reset release is taken on the first edge with rst low.
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1; din = FIPS_IN; inv = 1'b0;
    exp_q.push_back(FIPS_OUT);
    tick();
    chk("rst_hold_busy", {127'd0, busy}, 128'd0);
    chk("rst_hold_dout", dout, 128'd0);
    #2 rst = 1'b0;
    tick();
    start = 1'b0;
    din = ~FIPS_IN; inv = 1'b1;
    chk("rst_release_accept", {127'd0, busy}, 128'd1);
    finish("rst_release", -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
